// File: rtl/d1_l2_req_rr_arbiter.sv
// N-way arbiter for the D1 -> L2 request channel: round-robin with urgency hints,
// per-requester blocking and starvation forcing; the grant is locked until handshake.
module d1_l2_req_rr_arbiter #(
  parameter  int N_REQ    = 2,
  parameter  int MAX_WAIT = 15,
  localparam int IDX_W    = $clog2(N_REQ),
  localparam int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [N_REQ-1:0] req_valid_i,
  input  logic [N_REQ-1:0] req_block_i,
  input  logic [N_REQ-1:0] req_prio_i,
  input  logic             l2c_req_rdy_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] winner_idx_o,
  output logic             l2c_valid_o,
  output logic [N_REQ-1:0] transaction_ok_o,
  output logic [N_REQ-1:0] starve_o
);

  // state    | meaning
  // ST_IDLE  | no grant held; arbitrate over eligible requesters
  // ST_GRANT | r_win owns the L2 channel until handshake or withdrawal
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_win;
  logic [IDX_W-1:0] w_win_nxt;
  logic [IDX_W-1:0] r_rr;
  logic [IDX_W-1:0] w_rr_nxt;
  logic [WAIT_W-1:0] r_wait [N_REQ];

  logic [N_REQ-1:0] w_elig;
  logic [N_REQ-1:0] w_starve;
  logic [N_REQ-1:0] w_cur_oh;
  logic [N_REQ-1:0] w_elig_rearb;
  logic [IDX_W-1:0] w_rr_after;
  logic             w_l2_valid;
  logic             w_hs;
  logic             w_withdraw;

  // Starving requesters win outright (lowest index), else round-robin over the
  // urgent subset if any, else round-robin over everything eligible.
  function automatic logic [IDX_W-1:0] f_select(
    input logic [N_REQ-1:0] elig,
    input logic [N_REQ-1:0] starve,
    input logic [N_REQ-1:0] prio,
    input logic [IDX_W-1:0] ptr
  );
    logic [N_REQ-1:0] starving;
    logic [N_REQ-1:0] urgent;
    logic [N_REQ-1:0] pool;
    logic [IDX_W-1:0] res;
    logic             found;
    starving = elig & starve;
    urgent   = elig & prio;
    pool     = (|urgent) ? urgent : elig;
    res      = '0;
    found    = 1'b0;
    if (|starving) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && starving[i]) begin
          res   = IDX_W'(i);
          found = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && pool[i] && (i >= int'(ptr))) begin
          res   = IDX_W'(i);
          found = 1'b1;
        end
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && pool[i]) begin
          res   = IDX_W'(i);
          found = 1'b1;
        end
      end
    end
    return res;
  endfunction

  always_comb begin
    w_elig = req_valid_i & ~req_block_i;
    for (int i = 0; i < N_REQ; i++) begin
      w_starve[i] = (r_wait[i] == WAIT_W'(MAX_WAIT));
      w_cur_oh[i] = (r_win == IDX_W'(i));
    end
    w_elig_rearb = w_elig & ~w_cur_oh;
    w_l2_valid   = (r_state == ST_GRANT) && |(w_cur_oh & w_elig);
    w_hs         = w_l2_valid && l2c_req_rdy_i;
    w_withdraw   = (r_state == ST_GRANT) && !(|(w_cur_oh & req_valid_i));
    w_rr_after   = (r_win == IDX_W'(N_REQ - 1)) ? '0 : r_win + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_win   <= '0;
      r_rr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_win   <= w_win_nxt;
      r_rr    <= w_rr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_win_nxt   = r_win;
    w_rr_nxt    = r_rr;
    case (r_state)
      ST_IDLE: begin
        if (|w_elig) begin
          w_state_nxt = ST_GRANT;
          w_win_nxt   = f_select(w_elig, w_starve, req_prio_i, r_rr);
        end
      end
      ST_GRANT: begin
        if (w_hs) begin
          w_rr_nxt = w_rr_after;
          // Re-arbitrate with the advanced pointer so transfers can go back to back.
          if (|w_elig_rearb) begin
            w_win_nxt = f_select(w_elig_rearb, w_starve, req_prio_i, w_rr_after);
          end else begin
            w_state_nxt = ST_IDLE;
            w_win_nxt   = '0;
          end
        end else if (w_withdraw) begin
          w_state_nxt = ST_IDLE;
          w_win_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_win_nxt   = '0;
      end
    endcase
  end

  // Blocked cycles still count as waiting; only a handshake or dropping valid clears.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < N_REQ; i++) begin
        r_wait[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!req_valid_i[i] || (w_hs && w_cur_oh[i])) begin
          r_wait[i] <= '0;
        end else if (r_wait[i] != WAIT_W'(MAX_WAIT)) begin
          r_wait[i] <= r_wait[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_o          = '0;
    winner_idx_o     = '0;
    l2c_valid_o      = 1'b0;
    transaction_ok_o = '0;
    starve_o         = w_starve;
    if (r_state == ST_GRANT) begin
      grant_o      = w_cur_oh;
      winner_idx_o = r_win;
      l2c_valid_o  = w_l2_valid;
      if (w_hs) begin
        transaction_ok_o = w_cur_oh;
      end
    end
  end

endmodule

// File: tb/tb_d1_l2_req_rr_arbiter.sv
// Directed bench for d1_l2_req_rr_arbiter (3 requesters, MAX_WAIT=3): expected
// handshake winners are queued by the stimulus and checked by a separate monitor.
module tb_d1_l2_req_rr_arbiter;

  localparam int N_REQ    = 3;
  localparam int MAX_WAIT = 3;

  logic       clk_i;
  logic       rst_n_i;
  logic [2:0] req_valid_i;
  logic [2:0] req_block_i;
  logic [2:0] req_prio_i;
  logic       l2c_req_rdy_i;
  logic [2:0] grant_o;
  logic [1:0] winner_idx_o;
  logic       l2c_valid_o;
  logic [2:0] transaction_ok_o;
  logic [2:0] starve_o;

  int exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  d1_l2_req_rr_arbiter #(
    .N_REQ    (N_REQ),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .req_valid_i      (req_valid_i),
    .req_block_i      (req_block_i),
    .req_prio_i       (req_prio_i),
    .l2c_req_rdy_i    (l2c_req_rdy_i),
    .grant_o          (grant_o),
    .winner_idx_o     (winner_idx_o),
    .l2c_valid_o      (l2c_valid_o),
    .transaction_ok_o (transaction_ok_o),
    .starve_o         (starve_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [2:0] b, input logic [2:0] p, input logic r);
    req_valid_i   = v;
    req_block_i   = b;
    req_prio_i    = p;
    l2c_req_rdy_i = r;
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // Handshake monitor
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_n_i && ((transaction_ok_o != 3'b000) || (l2c_valid_o && l2c_req_rdy_i))) begin
        if (exp_q.size() == 0) begin
          chk("hs_unexpected", int'({transaction_ok_o, l2c_valid_o & l2c_req_rdy_i}), 0);
        end else begin
          int e;
          e = exp_q.pop_front();
          chk("hs_winner_idx", int'(winner_idx_o), e);
          chk("hs_transaction_ok", int'(transaction_ok_o), 1 << e);
          chk("hs_grant", int'(grant_o), 1 << e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b_win[4];
    logic [2:0] b_v[5];
    int e_win[9];
    logic [2:0] e_st[9];
    b_win = '{1, 2, 0, 1};
    b_v   = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b010};
    e_win = '{1, 2, 1, 0, 1, 2, 1, 2, 0};
    e_st  = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b000, 3'b100, 3'b000, 3'b001, 3'b001};

    rst_n_i = 1'b0;
    drive(3'b000, 3'b000, 3'b000, 1'b0);
    #1;
    chk("reset_grant", int'(grant_o), 0);
    chk("reset_idx", int'(winner_idx_o), 0);
    chk("reset_valid", int'(l2c_valid_o), 0);
    chk("reset_tok", int'(transaction_ok_o), 0);
    chk("reset_starve", int'(starve_o), 0);
    tick;
    tick;
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // Single request from requester 0
    tick; drive(3'b001, 3'b000, 3'b000, 1'b1); exp_q.push_back(0); #1;
    chk("single_idle_grant", int'(grant_o), 0);
    tick; drive(3'b001, 3'b000, 3'b000, 1'b1); #1;
    chk("single_grant", int'(grant_o), 1);
    chk("single_valid", int'(l2c_valid_o), 1);
    tick; drive(3'b000, 3'b000, 3'b000, 1'b1); #1;
    chk("single_back_idle_grant", int'(grant_o), 0);
    chk("single_back_idle_valid", int'(l2c_valid_o), 0);

    // Round-robin with wrap (pointer now 1): winners 1,2,0,1 with no gap
    for (int k = 0; k < 4; k++) exp_q.push_back(b_win[k]);
    for (int k = 0; k < 5; k++) begin
      tick; drive(b_v[k], 3'b000, 3'b000, 1'b1); #1;
      if (k > 0) chk("rr_grant", int'(grant_o), 1 << b_win[k-1]);
    end
    tick; drive(3'b000, 3'b000, 3'b000, 1'b1); #1;
    chk("rr_idle", int'(grant_o), 0);

    // Blocking holds the grant with valid low; blocked cycles count as waiting
    tick; drive(3'b010, 3'b000, 3'b000, 1'b1); exp_q.push_back(1);
    tick; drive(3'b010, 3'b010, 3'b000, 1'b1); #1;
    chk("block_grant_c1", int'(grant_o), 2);
    chk("block_valid_c1", int'(l2c_valid_o), 0);
    tick; drive(3'b010, 3'b010, 3'b000, 1'b1); #1;
    chk("block_grant_c2", int'(grant_o), 2);
    chk("block_valid_c2", int'(l2c_valid_o), 0);
    tick; drive(3'b010, 3'b000, 3'b000, 1'b1); #1;
    chk("block_release_valid", int'(l2c_valid_o), 1);
    chk("block_starve", int'(starve_o), 2);
    tick; drive(3'b000, 3'b000, 3'b000, 1'b1); #1;
    chk("block_after_grant", int'(grant_o), 0);
    chk("block_after_starve", int'(starve_o), 0);

    // Withdrawal without handshake (pointer stays at 2)
    tick; drive(3'b001, 3'b000, 3'b000, 1'b0);
    tick; drive(3'b001, 3'b000, 3'b000, 1'b0); #1;
    chk("wd_grant", int'(grant_o), 1);
    chk("wd_valid", int'(l2c_valid_o), 1);
    chk("wd_tok_rdy_low", int'(transaction_ok_o), 0);
    tick; drive(3'b000, 3'b000, 3'b000, 1'b0); #1;
    chk("wd_drop_valid", int'(l2c_valid_o), 0);
    chk("wd_drop_tok", int'(transaction_ok_o), 0);
    tick; drive(3'b111, 3'b000, 3'b000, 1'b1); exp_q.push_back(2); #1;
    chk("wd_idle_grant", int'(grant_o), 0);
    tick; drive(3'b100, 3'b000, 3'b000, 1'b1); #1;
    chk("wd_rr_unchanged", int'(grant_o), 4);
    tick; drive(3'b000, 3'b000, 3'b000, 1'b1);

    // Requesters 1,2 urgent forever: requester 0 only wins through starvation
    for (int k = 0; k < 9; k++) exp_q.push_back(e_win[k]);
    for (int k = 0; k < 10; k++) begin
      tick; drive((k == 9) ? 3'b001 : 3'b111, 3'b000, 3'b110, 1'b1); #1;
      if (k > 0) chk("starve_vec", int'(starve_o), int'(e_st[k-1]));
    end
    tick; drive(3'b000, 3'b000, 3'b000, 1'b1); #1;
    chk("starve_idle", int'(grant_o), 0);

    // Reset mid-transfer (pointer was 1, must restart from 0)
    tick; drive(3'b111, 3'b000, 3'b000, 1'b0);
    tick; tick; tick; #1;
    chk("mid_grant", int'(grant_o), 2);
    chk("mid_valid", int'(l2c_valid_o), 1);
    chk("mid_starve", int'(starve_o), 7);
    rst_n_i = 1'b0;
    #1;
    chk("mid_rst_grant", int'(grant_o), 0);
    chk("mid_rst_idx", int'(winner_idx_o), 0);
    chk("mid_rst_valid", int'(l2c_valid_o), 0);
    chk("mid_rst_tok", int'(transaction_ok_o), 0);
    chk("mid_rst_starve", int'(starve_o), 0);
    @(posedge clk_i);
    @(negedge clk_i);
    drive(3'b111, 3'b000, 3'b000, 1'b1);
    exp_q.push_back(0);
    exp_q.push_back(1);
    rst_n_i = 1'b1;
    tick; drive(3'b111, 3'b000, 3'b000, 1'b1); #1;
    chk("post_rst_grant", int'(grant_o), 1);
    tick; drive(3'b010, 3'b000, 3'b000, 1'b1); #1;
    chk("post_rst_second", int'(grant_o), 2);
    tick; drive(3'b000, 3'b000, 3'b000, 1'b1); #1;
    chk("post_rst_idle", int'(grant_o), 0);

    tick; tick;
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
